// File: rtl/bus_arb_pkg.sv
// Shared types for the two-master bus arbiter: FSM states, master ids, lock limit.
package bus_arb_pkg;
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;
  localparam int LOCK_MAX_DEFAULT = 16;

  function automatic master_id_t other(input master_id_t id);
    return ~id;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter: a lone requester wins, contention goes to ptr_i.
module rr_arb2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t ptr_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (ptr_i == M1) ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates LSU (m0) and debug loader (m1) onto one slave with same-cycle grant,
// lock support for read-modify-write, and 1-cycle read-response routing.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_bmask,
  output logic          m0_gnt,
  output logic          m0_rvld,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_bmask,
  output logic          m1_gnt,
  output logic          m1_rvld,
  output logic [DW-1:0] m1_rdata,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic [3:0]    s_bmask,
  input  logic [DW-1:0] s_rdata
);
  arb_state_e state_q, state_d;
  master_id_t ptr_q, ptr_d, owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       pend_q, pend_d;
  logic [1:0] rr_gnt, gnt;
  master_id_t win;
  logic       granted, win_we, win_lock;

  rr_arb2 u_rr_arb2 (
    .req_i ({m1_req, m0_req}),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // While locked the other master stalls regardless of the pointer.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (state_q)
        ARB:     gnt = rr_gnt;
        LOCK0:   gnt = {1'b0, m0_req};
        LOCK1:   gnt = {m1_req, 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  assign win      = gnt[1];
  assign granted  = |gnt;
  assign win_we   = (win == M1) ? m1_we   : m0_we;
  assign win_lock = (win == M1) ? m1_lock : m0_lock;
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign pend_d   = granted & ~win_we;
  assign owner_d  = win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= M0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      owner_q <= M0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: begin
        cnt_d = '0;
        if (m0_req && m1_req) ptr_d = other(win);
        if (granted && win_lock) begin
          state_d = (win == M1) ? LOCK1 : LOCK0;
          cnt_d   = 8'd1;
        end
      end
      LOCK0, LOCK1: begin
        cnt_d = cnt_inc;
        if (!granted) begin
          state_d = ARB;
          cnt_d   = '0;
        end else if (cnt_inc == 8'(LOCK_MAX)) begin
          // Forced release: this transfer still goes, then the other master gets priority.
          state_d = ARB;
          cnt_d   = '0;
          ptr_d   = other(win);
        end else if (!win_lock) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    m0_gnt   = gnt[0];
    m1_gnt   = gnt[1];
    s_req    = granted;
    s_we     = granted & win_we;
    s_bmask  = granted ? ((win == M1) ? m1_bmask : m0_bmask) : 4'b0000;
    s_addr   = (win == M1) ? m1_addr  : m0_addr;
    s_wdata  = (win == M1) ? m1_wdata : m0_wdata;
    m0_rvld  = pend_q & (owner_q == M0);
    m1_rvld  = pend_q & (owner_q == M1);
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level model of grants, locks and read routing,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LM = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata, s_rdata, m0_rdata, m1_rdata;
  logic [3:0]    m0_bmask, m1_bmask, s_bmask;
  logic          m0_gnt, m1_gnt, m0_rvld, m1_rvld, s_req, s_we;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: who holds a lock (-1 none), transfers done under it, priority, pending read owner.
  int lock_owner, lock_xfers, prio, pend_owner, win;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_bmask(m0_bmask), .m0_gnt(m0_gnt), .m0_rvld(m0_rvld),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_bmask(m1_bmask), .m1_gnt(m1_gnt), .m1_rvld(m1_rvld),
    .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_bmask(s_bmask), .s_rdata(s_rdata)
  );

  function automatic logic req_of(input int x);  return x == 1 ? m1_req  : m0_req;  endfunction
  function automatic logic we_of(input int x);   return x == 1 ? m1_we   : m0_we;   endfunction
  function automatic logic lock_of(input int x); return x == 1 ? m1_lock : m0_lock; endfunction
  function automatic logic [AW-1:0] addr_of(input int x); return x == 1 ? m1_addr : m0_addr; endfunction
  function automatic logic [DW-1:0] wd_of(input int x);   return x == 1 ? m1_wdata : m0_wdata; endfunction
  function automatic logic [3:0] bm_of(input int x);      return x == 1 ? m1_bmask : m0_bmask; endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lock_owner = -1;
    lock_xfers = 0;
    prio       = 0;
    pend_owner = -1;
  endtask

  function automatic int predict();
    if (rst) return -1;
    if (lock_owner >= 0) return req_of(lock_owner) ? lock_owner : -1;
    if (m0_req && m1_req) return prio;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  task automatic idle_inputs();
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_bmask = 4'hF; m1_bmask = 4'hF;
  endtask

  // Called shortly after a rising edge, once inputs for this cycle are set.
  task automatic settle_and_check();
    #3;
    if (rst) model_reset();
    win = predict();
    chk("m0_gnt", 64'(m0_gnt), 64'(win == 0));
    chk("m1_gnt", 64'(m1_gnt), 64'(win == 1));
    chk("s_req", 64'(s_req), 64'(win >= 0));
    chk("s_we", 64'(s_we), 64'(win >= 0 && we_of(win)));
    chk("s_bmask", 64'(s_bmask), win >= 0 ? 64'(bm_of(win)) : 64'd0);
    if (win >= 0) begin
      chk("s_addr", 64'(s_addr), 64'(addr_of(win)));
      if (we_of(win)) chk("s_wdata", 64'(s_wdata), 64'(wd_of(win)));
    end
    chk("m0_rvld", 64'(m0_rvld), 64'(pend_owner == 0));
    chk("m1_rvld", 64'(m1_rvld), 64'(pend_owner == 1));
    if (pend_owner == 0) chk("m0_rdata", 64'(m0_rdata), 64'(s_rdata));
    if (pend_owner == 1) chk("m1_rdata", 64'(m1_rdata), 64'(s_rdata));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (lock_owner < 0) begin
        if (m0_req && m1_req) prio = 1 - win;
        if (win >= 0 && lock_of(win)) begin
          lock_owner = win;
          lock_xfers = 1;
        end
      end else if (win < 0) begin
        lock_owner = -1;
      end else begin
        lock_xfers++;
        if (lock_xfers == LM) begin
          prio       = 1 - lock_owner;
          lock_owner = -1;
        end else if (!lock_of(win)) begin
          lock_owner = -1;
        end
      end
      pend_owner = (win >= 0 && !we_of(win)) ? win : -1;
    end
    #1;
  endtask

  task automatic cycle();
    settle_and_check();
    advance();
  endtask

  initial begin
    int m0_cnt;
    model_reset();
    idle_inputs();
    s_rdata = '0;
    rst = 1'b1;
    #1;
    settle_and_check();
    chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("rst_m0_rvld", 64'(m0_rvld), 64'd0);
    advance();
    cycle();
    rst = 1'b0;
    cycle();

    // Single read from m0, response next cycle.
    m0_req = 1; m0_addr = 16'h0010;
    settle_and_check();
    chk("r1_m0_gnt", 64'(m0_gnt), 64'd1);
    chk("r1_s_addr", 64'(s_addr), 64'h0010);
    advance();
    idle_inputs(); s_rdata = 32'hDEADBEEF;
    settle_and_check();
    chk("r1_m0_rvld", 64'(m0_rvld), 64'd1);
    chk("r1_m0_rdata", 64'(m0_rdata), 64'hDEADBEEF);
    chk("r1_m1_rvld", 64'(m1_rvld), 64'd0);
    advance();

    // Continuous contention alternates; the fifth grant leaves priority with m1.
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    for (int i = 0; i < 5; i++) begin
      settle_and_check();
      chk("alt_m0_gnt", 64'(m0_gnt), 64'(i % 2 == 0));
      chk("alt_m1_gnt", 64'(m1_gnt), 64'(i % 2 == 1));
      advance();
    end

    // m1 locked read then unlocking write; m0 stalls both cycles.
    m0_we = 1; m1_we = 0; m1_lock = 1; m1_addr = 16'h0100;
    settle_and_check();
    chk("lk_c1_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("lk_c1_m0_gnt", 64'(m0_gnt), 64'd0);
    advance();
    m1_we = 1; m1_lock = 0;
    settle_and_check();
    chk("lk_c2_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("lk_c2_m0_gnt", 64'(m0_gnt), 64'd0);
    advance();
    m1_req = 0;
    settle_and_check();
    chk("lk_c3_m0_gnt", 64'(m0_gnt), 64'd1);
    advance();
    idle_inputs();
    cycle();

    // Lock held past LOCK_MAX is forcibly released after 16 transfers.
    m0_req = 1; m0_we = 1; m0_lock = 1; m1_req = 1; m1_we = 1;
    m0_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      settle_and_check();
      if (i <= 16) m0_cnt += int'(m0_gnt);
      if (i == 17) chk("lmax_m1_gnt_c17", 64'(m1_gnt), 64'd1);
      if (i == 16) chk("lmax_m1_gnt_c16", 64'(m1_gnt), 64'd0);
      advance();
    end
    chk("lmax_m0_xfers", 64'(m0_cnt), 64'd16);
    idle_inputs();
    cycle();

    // Reset before a granted read's response edge: no response, pointer back to m0.
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    cycle();
    m1_req = 0; m0_we = 0;
    settle_and_check();
    chk("rst_rd_m0_gnt", 64'(m0_gnt), 64'd1);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    idle_inputs();
    settle_and_check();
    chk("rst_rd_m0_rvld", 64'(m0_rvld), 64'd0);
    advance();
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    settle_and_check();
    chk("rst_ptr_m0_gnt", 64'(m0_gnt), 64'd1);
    advance();

    // Pending response dropped asynchronously by reset.
    idle_inputs(); m0_req = 1;
    cycle();
    idle_inputs();
    rst = 1'b1;
    settle_and_check();
    chk("async_m0_rvld", 64'(m0_rvld), 64'd0);
    advance();
    rst = 1'b0;
    cycle();

    // Back-to-back reads from alternating masters.
    m0_req = 1; m0_addr = 16'h0004;
    settle_and_check();
    chk("b2b_m0_gnt", 64'(m0_gnt), 64'd1);
    advance();
    idle_inputs(); m1_req = 1; m1_addr = 16'h0008; s_rdata = 32'h11112222;
    settle_and_check();
    chk("b2b_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("b2b_s_addr", 64'(s_addr), 64'h0008);
    chk("b2b_m0_rvld", 64'(m0_rvld), 64'd1);
    chk("b2b_m0_rdata", 64'(m0_rdata), 64'h11112222);
    advance();
    idle_inputs(); s_rdata = 32'h33334444;
    settle_and_check();
    chk("b2b_m1_rvld", 64'(m1_rvld), 64'd1);
    chk("b2b_m1_rdata", 64'(m1_rdata), 64'h33334444);
    chk("b2b_m0_rvld2", 64'(m0_rvld), 64'd0);
    advance();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      m0_req   = ($urandom_range(0, 3) != 0);
      m1_req   = ($urandom_range(0, 3) != 0);
      m0_we    = $urandom_range(0, 1) == 1;
      m1_we    = $urandom_range(0, 1) == 1;
      m0_lock  = ($urandom_range(0, 2) == 0);
      m1_lock  = ($urandom_range(0, 2) == 0);
      m0_addr  = AW'($urandom);
      m1_addr  = AW'($urandom);
      m0_wdata = $urandom;
      m1_wdata = $urandom;
      m0_bmask = 4'($urandom);
      m1_bmask = 4'($urandom);
      s_rdata  = $urandom;
      rst      = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: AW, 16, data-bus address width (matches LSU addr[15:0]).
REQ-002 Parameter: DW, 32, data width.
REQ-003 Parameter: LOCK_MAX, 16, max consecutive cycles a lock may hold ownership (range 2..255).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 m0_req/m1_req  input  1  requester transfer request (m0 = core LSU path, m1 = debug/program loader).
REQ-007 mX_we  input  1  1 = write, 0 = read.
REQ-008 mX_lock  input  1  hold ownership after this transfer (read-modify-write sequences).
REQ-009 mX_addr  input  AW  byte address.
REQ-010 mX_wdata  input  DW  write data.
REQ-011 mX_bmask  input  4  byte-enable mask.
REQ-012 mX_gnt  output  1  transfer accepted this cycle.
REQ-013 mX_rvld  output  1  read data valid for this requester.
REQ-014 mX_rdata  output  DW  read data (meaningful only with mX_rvld).
REQ-015 s_req, s_we, s_addr[AW], s_wdata[DW], s_bmask[4]  output  shared-slave request bus.
REQ-016 s_rdata  input  DW  slave read data, valid exactly 1 cycle after an accepted read.

Function
REQ-017 Grant SHALL be combinational: mX_gnt asserts in the same cycle as mX_req when X wins; s_* SHALL carry the winner's fields; at most one gnt per cycle.
REQ-018 s_req SHALL equal (m0_gnt | m1_gnt); when neither granted, s_we=0, s_bmask=0.
REQ-019 FSM states ARB, LOCK0, LOCK1.
REQ-020 ARB: single requester wins; both requesting -> winner = prio pointer; pointer then SHALL flip to the loser.
REQ-021 ARB -> LOCKx when mX granted with mX_lock=1; lock counter loads 1.
REQ-022 LOCKx: only mX may be granted; other requester stalls (gnt=0) regardless of pointer.
REQ-023 LOCKx -> ARB when mX granted with mX_lock=0, or mX_req=0 for one cycle, or lock counter reaches LOCK_MAX (forced release; the transfer at count LOCK_MAX is still granted).
REQ-024 Lock counter increments on each cycle spent in LOCKx, 8-bit, never wraps; forced release SHALL set pointer to the other requester.
REQ-025 Read tracking: on a granted read, register pend=1 and owner=X; next cycle mX_rvld=1 for owner only, mX_rdata = s_rdata.
REQ-026 Back-to-back reads from alternating requesters SHALL be accepted every cycle; each response routed by its own registered owner (throughput 1 transfer/cycle).
REQ-027 Writes produce no rvld.
REQ-028 Both mX_rdata outputs MAY be driven by s_rdata; correctness depends only on rvld.

Reset
REQ-029 On rst: state=ARB, pointer=m0, lock counter=0, pend=0; mX_rvld=0 immediately (asynchronous).
REQ-030 Reset mid-operation: a pending read response SHALL be dropped; any lock SHALL be released.
REQ-031 gnt outputs SHALL be 0 while rst is high.

Structure
REQ-032 Shared package bus_arb_pkg: arb_state_e {ARB, LOCK0, LOCK1}, master_id_t (1 bit), LOCK_MAX default.
REQ-033 One sub-module rr_arb2: two requests plus pointer in, one-hot grant out, purely combinational.
REQ-034 Target 150-250 lines RTL total.

Verification
REQ-035 Reset release, m0_req only, read addr 0x0010 -> m0_gnt same cycle, s_addr=0x0010; next cycle m0_rvld=1, m0_rdata=s_rdata (0xDEADBEEF), m1_rvld=0.
REQ-036 Both request continuously, lock=0 -> grants m0,m1,m0,m1 on successive cycles.
REQ-037 m1 read addr 0x0100 with lock=1, then write 0x0100 with lock=0 while m0 requests -> m0_gnt=0 for both cycles, m0 granted the cycle after.
REQ-038 m0 holds lock=1 and req for 20 cycles, m1 requesting, LOCK_MAX=16 -> m0 granted 16 transfers, m1_gnt on cycle 17.
REQ-039 m0 read granted, rst pulsed high before next edge -> m0_rvld stays 0, state ARB, pointer m0.
REQ-040 Alternating reads m0 (0x0004), m1 (0x0008) on consecutive cycles -> rvld for m0 then m1 on consecutive cycles, each with its own s_rdata value.
